// File: rtl/booth_r4_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, Booth digits
// and the triplet-to-digit recoding function.
package booth_r4_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} digit_t;

    // Triplet is {b[2i+1], b[2i], b[2i-1]}.
    function automatic digit_t recode(input logic [2:0] triplet);
        digit_t d;
        case (triplet)
            3'b001, 3'b010: d = POS1;
            3'b011:         d = POS2;
            3'b100:         d = NEG2;
            3'b101, 3'b110: d = NEG1;
            default:        d = ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_r4_pp.sv
// Combinational Booth partial-product generator: selects 0/+-M/+-2M from the
// extended multiplier and shifts it left by two bits per digit position.
module booth_r4_pp #(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH/2+2)
) (
    input  logic [2*WIDTH+1:0] i_m_ext,
    input  logic [2:0]         i_digit,
    input  logic [CNT_W-1:0]   i_idx,
    output logic [2*WIDTH+1:0] o_pp
);
    import booth_r4_pkg::*;

    logic [2*WIDTH+1:0] w_mult;

    always_comb begin
        w_mult = '0;
        case (digit_t'(i_digit))
            POS1:    w_mult = i_m_ext;
            POS2:    w_mult = i_m_ext << 1;
            NEG1:    w_mult = -i_m_ext;
            NEG2:    w_mult = -(i_m_ext << 1);
            default: w_mult = '0;
        endcase
    end

    assign o_pp = w_mult << {i_idx, 1'b0};

endmodule

// File: rtl/booth_r4_mul_param.sv
// Iterative radix-4 Booth multiplier, one digit per clock, signed/unsigned per op.
// Optional early termination when the remaining digits are all zero: BOOTH_R4_EARLY_TERM_EN.
module booth_r4_mul_param #(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH/2+2)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 op_start,
    input  logic                 op_clear,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplicand,
    output logic                 busy,
    output logic                 op_done,
    output logic [2*WIDTH-1:0]   result
);
    import booth_r4_pkg::*;

    localparam int PW = 2*WIDTH+2;
    localparam logic [CNT_W-1:0] ITER_S = CNT_W'(WIDTH/2);
    localparam logic [CNT_W-1:0] ITER_U = CNT_W'(WIDTH/2+1);

    state_t               r_state;
    state_t               w_state_next;
    logic [PW-1:0]        r_m_ext;
    logic [WIDTH+1:0]     r_b_ext;
    logic                 r_signed;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_busy;
    logic                 r_done;

    logic [WIDTH+2:0]     w_b_app;
    logic [2:0]           w_triplet;
    digit_t               w_digit;
    logic [PW-1:0]        w_pp;
    logic [2*WIDTH-1:0]   w_sum;
    logic [CNT_W-1:0]     w_cnt_inc;
    logic [CNT_W-1:0]     w_iter;
    logic                 w_start;
    logic                 w_last;
    logic                 w_rest_zero;

    // Appending the implicit b[-1]=0 lets digit i read bits [2i+2:2i] directly.
    assign w_b_app   = {r_b_ext, 1'b0};
    assign w_triplet = w_b_app[{r_cnt, 1'b0} +: 3];
    assign w_digit   = recode(w_triplet);
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_iter    = r_signed ? ITER_S : ITER_U;
    assign w_start   = op_start && !op_clear && (r_state != BUSY);

`ifdef BOOTH_R4_EARLY_TERM_EN
    logic [WIDTH+1:0] w_b_rest;
    // Arithmetic shift replicates the top bit, so "all equal" becomes all-0 or all-1.
    assign w_b_rest    = $signed(r_b_ext) >>> ({r_cnt, 1'b0} + 1);
    assign w_rest_zero = (w_b_rest == '0) || (w_b_rest == '1);
`else
    assign w_rest_zero = 1'b0;
`endif

    assign w_last = (w_cnt_inc == w_iter) || w_rest_zero;

    booth_r4_pp #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_pp (
        .i_m_ext (r_m_ext),
        .i_digit (w_digit),
        .i_idx   (r_cnt),
        .o_pp    (w_pp)
    );

    assign w_sum = r_result + w_pp[2*WIDTH-1:0];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: if (w_start) w_state_next = BUSY;
            BUSY:       if (w_last)  w_state_next = DONE;
            default:    w_state_next = IDLE;
        endcase
        if (op_clear) w_state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == BUSY);
            r_done  <= (w_state_next == DONE);
        end
    end

    // Operand snapshot and accumulator; clear outranks start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_ext  <= '0;
            r_b_ext  <= '0;
            r_signed <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (op_clear) begin
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_start) begin
            r_m_ext  <= signed_mode ? {{(WIDTH+2){multiplier[WIDTH-1]}}, multiplier}
                                    : {{(WIDTH+2){1'b0}}, multiplier};
            r_b_ext  <= signed_mode ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                                    : {2'b00, multiplicand};
            r_signed <= signed_mode;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (r_state == BUSY) begin
            r_result <= w_sum;
            r_cnt    <= w_cnt_inc;
        end
    end

    assign busy    = r_busy;
    assign op_done = r_done;
    assign result  = r_result;

endmodule
